denise_sprite_engine: RTL
=========================

DENISE_SPRITE_ENGINE -- requirements
Module: denise_sprite_engine

Interface
REQ-001 Parameter NSPR, default 8: sprite channel count; SHALL be even, legal values 2, 4, 6 or 8.
REQ-002 Parameter SPRBASE, default 9'h140: register base; sprite n SHALL occupy SPRBASE+8n: POS +0, CTL +2, DATA +4, DATB +6.
REQ-003 Parameter FMODE_ADR, default 9'h1fc: fetch-mode register address.
REQ-004 clk  in  1  28MHz clock; one clock domain; all state SHALL change only on rising edge of clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 clk7_en  in  1  pixel/register qualifier; all register writes, shifts and output updates SHALL occur only when high.
REQ-007 aga  in  1  enables FMODE writes.
REQ-008 reg_address_in  in  8 [8:1]  register write address; a write occurs on any clk7_en cycle with a matching address.
REQ-009 data_in  in  16  register write data.
REQ-010 chip64  in  64  wide sprite data used for DATA/DATB writes when fetch width exceeds 16.
REQ-011 hpos  in  9  horizontal beam position.
REQ-012 sprena  in  1  global sprite output enable.
REQ-013 esprm, osprm  in  4 each  even/odd sprite colour bank bits.
REQ-014 clx_rd  in  1  collision register read strobe (clk7_en-qualified).
REQ-015 nsprite  out  NSPR  per-sprite non-transparent flags, registered.
REQ-016 sprdata  out  8  prioritised colour index, registered.
REQ-017 clxdat  out  6  sprite-group collision flags.

Function
REQ-018 fetch width W from FMODE[3:2]: 00->16, 01/10->32, 11->64 bits; FMODE write ignored when aga=0.
REQ-019 per sprite: hstart = {POS[7:0], CTL[0]}; attach = CTL[7] (odd sprites only; even-sprite attach bit ignored).
REQ-020 per-sprite FSM states DISARMED, ARMED, SHIFTING.
REQ-021 CTL write -> DISARMED from any state; shifting stops and the shifter clears in the same cycle.
REQ-022 DATA write -> ARMED; DATA holding register loaded (data_in if W=16, else low W bits of chip64, left-justified).
REQ-023 DATB write loads DATB holding register identically; no state change.
REQ-024 ARMED or SHIFTING with hpos==hstart on a clk7_en cycle -> load both shifters from holding, bit counter = W, state SHIFTING; a match during SHIFTING reloads and restarts (retrigger).
REQ-025 SHIFTING: each clk7_en shifts both shifters MSB-first, decrements counter, zero-fills; counter reaching 0 -> ARMED, output pair 00.
REQ-026 pair value per sprite = {DATB bit, DATA bit} at shifter MSB; 00 while DISARMED or ARMED.
REQ-027 non-transparent(n) = sprena AND pair(n)!=00.
REQ-028 priority: lowest-numbered non-transparent group (g = n/2) wins.
REQ-029 within winning group g: odd attach set -> {osprm, pair(odd), pair(even)}; else even non-transparent -> {esprm, g[1:0], pair(even)}; else {osprm, g[1:0], pair(odd)}; no group active -> 8'h00.
REQ-030 nsprite and sprdata SHALL be registered: value for pixel at shift cycle k appears after the clk7_en edge ending k (latency 1 clk7_en cycle).
REQ-031 collision: bit index for group pair (i<j) enumerated (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) -> bits 0..5; set when both groups non-transparent in the same pixel, sprena ignored.
REQ-032 clxdat bits for groups >= NSPR/2 SHALL read 0.
REQ-033 clx_rd clears clxdat on the following edge; simultaneous new collision and clx_rd -> collision bit remains set.
REQ-034 simultaneous CTL write and hpos match on same sprite -> CTL write wins (DISARMED).
REQ-035 simultaneous DATA write and hpos match -> old holding value loaded into shifter, new value stored to holding.

Reset
REQ-036 reset_n low SHALL asynchronously clear FMODE, POS, CTL, holding registers, shifters, counters, clxdat; all FSMs DISARMED; nsprite=0, sprdata=8'h00.
REQ-037 reset asserted mid-shift SHALL abort output within the reset assertion; first enabled pixel after release is 00.

Verification
REQ-038 W=16: sprite 0 POS=8'h40, CTL=0, DATB=0, DATA=16'h8001, hpos hits 9'h080 -> nsprite[0]=1, sprdata=8'h01 first pixel; 14 pixels 8'h00; last pixel 8'h01; then ARMED, 00.
REQ-039 sprites 2,3 overlap, CTL3[7]=1, pairs 10/01 -> sprdata={osprm,2'b01,2'b10}; CTL3[7]=0 -> {esprm,2'b01,2'b10}.
REQ-040 sprites 1 and 6 overlap -> sprdata from sprite 1; clxdat bit 2 set; clx_rd -> clxdat=0 next cycle unless overlap persists.
REQ-041 aga=1, FMODE=16'h000c, chip64=64'h8000_0000_0000_0001 via DATA -> 64 shift pixels, non-zero at pixel 0 and pixel 63 only.
REQ-042 CTL write mid-shift -> nsprite bit 0 next registered cycle; later hpos match produces no output until DATA written.
REQ-043 reset_n pulsed low mid-shift with NSPR=4 -> all outputs 0 immediately; clxdat[5:3] stay 0 under any stimulus.

Source files
------------

// File: rtl/denise_sprite_engine.sv
// denise_sprite_engine
// Hardware sprite channels for the Denise video path. Each channel holds a
// start position, an attach bit and two data words (DATA/DATB) written through
// the custom register bus. When the beam reaches a sprite's horizontal start,
// both words are shifted out MSB-first as a two-bit colour pair. Pairs are
// prioritised by group (two sprites per group) into an 8-bit colour index.
// Overlapping groups are accumulated in a sticky collision register.
//
// Ports
//   clk            28 MHz clock
//   reset_n        asynchronous active-low reset
//   clk7_en        pixel/register qualifier; all state moves only when high
//   aga            allows FMODE writes
//   reg_address_in register address bits [8:1]
//   data_in        register write data
//   chip64         wide fetch data used when the fetch width exceeds 16 bits
//   hpos           horizontal beam position
//   sprena         global sprite output enable
//   esprm/osprm    colour bank bits for even/odd sprites
//   clx_rd         collision register read strobe (clears it)
//   nsprite        registered per-sprite non-transparent flags
//   sprdata        registered prioritised colour index
//   clxdat         sticky sprite-group collision flags
module denise_sprite_engine #(
  parameter int         NSPR      = 8,
  parameter logic [8:0] SPRBASE   = 9'h140,
  parameter logic [8:0] FMODE_ADR = 9'h1fc
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk7_en,
  input  logic            aga,
  input  logic [8:1]      reg_address_in,
  input  logic [15:0]     data_in,
  input  logic [63:0]     chip64,
  input  logic [8:0]      hpos,
  input  logic            sprena,
  input  logic [3:0]      esprm,
  input  logic [3:0]      osprm,
  input  logic            clx_rd,
  output logic [NSPR-1:0] nsprite,
  output logic [7:0]      sprdata,
  output logic [5:0]      clxdat
);

  localparam int NGRP = NSPR / 2;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  logic [1:0]        r_fmode;
  logic              w_wrFmode;
  logic [6:0]        w_width;
  logic [63:0]       w_fill;
  logic [2*NSPR-1:0] w_pairs;
  logic [NGRP-1:0]   w_grpAttach;
  logic [NSPR-1:0]   w_nt;
  logic [3:0]        w_grpAny;
  logic [5:0]        w_clxNew;
  logic [7:0]        w_sprdata;
  logic [NSPR-1:0]   r_nsprite;
  logic [7:0]        r_sprdata;
  logic [5:0]        r_clx;

  assign w_wrFmode = clk7_en && aga && (reg_address_in == FMODE_ADR[8:1]);

  // Only FMODE[3:2] (fetch width) matters to the sprite path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fmode <= 2'b00;
    end else if (w_wrFmode) begin
      r_fmode <= data_in[3:2];
    end
  end

  // Fetch width and the left-justified word loaded into DATA/DATB holding regs.
  always_comb begin
    w_width = 7'd32;
    w_fill  = {chip64[31:0], 32'h0};
    case (r_fmode)
      2'b00: begin
        w_width = 7'd16;
        w_fill  = {data_in, 48'h0};
      end
      2'b11: begin
        w_width = 7'd64;
        w_fill  = chip64;
      end
      default: ;
    endcase
  end

  for (genvar n = 0; n < NSPR; n++) begin : g_spr
    localparam logic [8:0] APOS = SPRBASE + 9'(8 * n);
    localparam logic [8:0] ACTL = APOS + 9'd2;
    localparam logic [8:0] ADAT = APOS + 9'd4;
    localparam logic [8:0] ADTB = APOS + 9'd6;

    state_t      r_state;
    logic [7:0]  r_pos;
    logic        r_hlsb;
    logic [63:0] r_data;
    logic [63:0] r_datb;
    logic [63:0] r_shA;
    logic [63:0] r_shB;
    logic [6:0]  r_cnt;
    logic        w_wrPos;
    logic        w_wrCtl;
    logic        w_wrData;
    logic        w_wrDatb;
    logic        w_match;

    assign w_wrPos  = clk7_en && (reg_address_in == APOS[8:1]);
    assign w_wrCtl  = clk7_en && (reg_address_in == ACTL[8:1]);
    assign w_wrData = clk7_en && (reg_address_in == ADAT[8:1]);
    assign w_wrDatb = clk7_en && (reg_address_in == ADTB[8:1]);
    assign w_match  = clk7_en && (r_state != DISARMED) && (hpos == {r_pos, r_hlsb});

    // Channel FSM. A CTL write beats everything; a start match beats a
    // simultaneous DATA write, so the shifter takes the old holding value
    // while the new word still lands in the holding register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= DISARMED;
        r_pos   <= 8'h00;
        r_hlsb  <= 1'b0;
        r_data  <= 64'h0;
        r_datb  <= 64'h0;
        r_shA   <= 64'h0;
        r_shB   <= 64'h0;
        r_cnt   <= 7'd0;
      end else begin
        if (w_wrPos)  r_pos  <= data_in[7:0];
        if (w_wrCtl)  r_hlsb <= data_in[0];
        if (w_wrData) r_data <= w_fill;
        if (w_wrDatb) r_datb <= w_fill;
        if (w_wrCtl) begin
          r_state <= DISARMED;
          r_shA   <= 64'h0;
          r_shB   <= 64'h0;
          r_cnt   <= 7'd0;
        end else if (w_match) begin
          r_shA   <= r_data;
          r_shB   <= r_datb;
          r_cnt   <= w_width;
          r_state <= SHIFTING;
        end else if (clk7_en) begin
          if (r_state == SHIFTING) begin
            r_shA <= r_shA << 1;
            r_shB <= r_shB << 1;
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) r_state <= ARMED;
          end
          if (w_wrData) r_state <= ARMED;
        end
      end
    end

    assign w_pairs[2*n +: 2] = (r_state == SHIFTING) ? {r_shB[63], r_shA[63]} : 2'b00;

    // Only odd channels carry a meaningful attach bit.
    if (n % 2 == 1) begin : g_att
      logic r_attach;

      // Attach bit latched from CTL[7].
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_attach <= 1'b0;
        end else if (w_wrCtl) begin
          r_attach <= data_in[7];
        end
      end

      assign w_grpAttach[n/2] = r_attach;
    end
  end

  // Priority: walk groups from highest to lowest so the lowest active one
  // is written last and wins.
  always_comb begin
    w_nt      = '0;
    w_grpAny  = '0;
    w_sprdata = 8'h00;
    for (int n = 0; n < NSPR; n++) begin
      w_nt[n] = sprena && (w_pairs[2*n +: 2] != 2'b00);
    end
    for (int g = 0; g < NGRP; g++) begin
      w_grpAny[g] = |w_pairs[4*g +: 4];
    end
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (w_nt[2*g] || w_nt[2*g+1]) begin
        if (w_grpAttach[g]) begin
          w_sprdata = {osprm, w_pairs[4*g+2 +: 2], w_pairs[4*g +: 2]};
        end else if (w_nt[2*g]) begin
          w_sprdata = {esprm, 2'(g), w_pairs[4*g +: 2]};
        end else begin
          w_sprdata = {osprm, 2'(g), w_pairs[4*g+2 +: 2]};
        end
      end
    end
  end

  // Group pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); absent groups read 0.
  assign w_clxNew = {w_grpAny[2] & w_grpAny[3], w_grpAny[1] & w_grpAny[3],
                     w_grpAny[1] & w_grpAny[2], w_grpAny[0] & w_grpAny[3],
                     w_grpAny[0] & w_grpAny[2], w_grpAny[0] & w_grpAny[1]};

  // Output registers; a read clears collisions but a fresh one still sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nsprite <= '0;
      r_sprdata <= 8'h00;
      r_clx     <= 6'h00;
    end else if (clk7_en) begin
      r_nsprite <= w_nt;
      r_sprdata <= w_sprdata;
      r_clx     <= (clx_rd ? 6'h00 : r_clx) | w_clxNew;
    end
  end

  assign nsprite = r_nsprite;
  assign sprdata = r_sprdata;
  assign clxdat  = r_clx;

endmodule
